// File: rtl/mmio_uart_rx.sv
// Memory-mapped serial receiver: rx line -> byte FIFO -> DATA/STATUS registers on the mem_* bus.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err flag in STATUS bit3.
module mmio_uart_rx #(
   parameter logic [31:0] BASE_ADDR = 32'h10000008,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned FIFO_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic        rx,
   output logic        irq_rx
);
   localparam int unsigned DEPTH = 2**FIFO_LOG2;
   localparam logic [15:0] FULL_CNT = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2 - 1);
   localparam logic [FIFO_LOG2:0] PTR_ONE = {{FIFO_LOG2{1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q, rx_last_q;
   logic [15:0]        cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               irq_q, irq_d;
   logic [7:0]         fifo_mem [DEPTH];
   logic               push, frame_set, mem_we, status_b3;
   logic               hit, rd_hit, wr_status, flush, pop, empty, full;
   logic               unused_bits;
`ifdef UART_RX_PARITY_EN
   logic               parity_err_q, parity_err_d, par_bad_q, par_bad_d, parity_set;
   assign unused_bits = ^{mem_wdata[31:5], mem_wdata[0], mem_wmask[3:1], mem_addr[1:0]};
   assign status_b3   = parity_err_q;
`else
   assign unused_bits = ^{mem_wdata[31:4], mem_wdata[0], mem_wmask[3:1], mem_addr[1:0]};
   assign status_b3   = 1'b0;
`endif

   assign hit       = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
   assign rd_hit    = hit && !mem_write;
   assign wr_status = hit && mem_write && mem_addr[2] && mem_wmask[0];
   assign flush     = wr_status && mem_wdata[3];
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                      (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
   assign pop       = rd_hit && !mem_addr[2] && !empty;

   // Receive FSM: all sampling uses the synchronised line sync2_q.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d  = par_bad_q;
      parity_set = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            if (!sync2_q && rx_last_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d   = 16'd0;
               state_d = sync2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = 16'd0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_q == 3'd7) state_d = S_PARITY;
`else
               if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d      = 16'd0;
               par_bad_d  = (sync2_q != ^shift_q);
               parity_set = par_bad_d;
               state_d    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_CNT) begin
               state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
               push = sync2_q && !par_bad_q;
`else
               push = sync2_q;
`endif
               frame_set = !sync2_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pointers and sticky flags; flush beats push, pop is applied before push.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      mem_we      = 1'b0;
      if (wr_status && mem_wdata[1]) overrun_d = 1'b0;
      if (wr_status && mem_wdata[2]) frame_err_d = 1'b0;
      if (frame_set) frame_err_d = 1'b1;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push) begin
            if (full && !pop) begin
               overrun_d = 1'b1;
            end else begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
         end
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
      if (wr_status && mem_wdata[4]) parity_err_d = 1'b0;
      if (parity_set) parity_err_d = 1'b1;
`endif
      rdata_d = 32'h0;
      if (rd_hit) begin
         if (mem_addr[2])
            rdata_d = {28'h0, status_b3, frame_err_q, overrun_q, !empty};
         else if (!empty)
            rdata_d = {1'b1, 23'h0, fifo_mem[rd_ptr_q[FIFO_LOG2-1:0]]};
      end
      irq_d = !empty;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rx_last_q   <= 1'b1;
         cnt_q       <= 16'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rdata_q     <= 32'h0;
         irq_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
         par_bad_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= rx;
         sync2_q     <= sync1_q;
         rx_last_q   <= sync2_q;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
         par_bad_q    <= par_bad_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) fifo_mem[wr_ptr_q[FIFO_LOG2-1:0]] <= shift_q;
   end

   assign mem_rdata = rdata_q;
   assign irq_rx    = irq_q;
endmodule
